ysyx_24110026_ifu: RTL and testbench

Instruction fetch unit for the RV32E single-issue core. It owns the program counter and issues in-order word fetches to instruction memory over a valid/ready request channel. Returned words are held with their PCs in a small reservation buffer and presented to the decoder over a valid/ready handshake. A one-cycle redirect from execute (branch/jump target) flushes all in-flight and buffered fetches.

---
 rtl/ysyx_24110026_ifu.sv | 154 +++++++++++++++
 tb/tb_ysyx_24110026_ifu.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24110026_ifu.sv
// ---------------------------------------------------------------------------
// ysyx_24110026_ifu -- instruction fetch unit for the RV32E single-issue core.
//
// Owns the program counter, issues in-order word fetches to instruction
// memory and keeps each returned word, together with its PC, in a small
// circular reservation buffer until the decoder takes it. A redirect from
// execute throws away every buffered and in-flight fetch.
//
// Ports
//   clk, rst           : rising-edge clock, synchronous active-high reset
//   imem_req_*         : fetch request channel (valid/ready, word address)
//   imem_resp_*        : in-order fetch responses, one per accepted request
//   redirect_valid/_pc : replace the fetch stream this cycle
//   inst_valid/_ready  : decoder handshake, with inst and inst_pc
// ---------------------------------------------------------------------------
module ysyx_24110026_ifu #(
    parameter logic [31:0] RESET_PC  = 32'h8000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    logic [31:0]                  fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]             alloc_q, alloc_d;
    logic [PTR_W-1:0]             fill_q, fill_d;
    logic [PTR_W-1:0]             head_q, head_d;
    logic [CNT_W-1:0]             count_q, count_d;
    // pend: accepted requests still owed a response that belong to live slots.
    // drop: responses still owed for requests killed by a redirect.
    // drop > 0 blocks new requests, so the two are never both non-zero.
    logic [CNT_W-1:0]             pend_q, pend_d;
    logic [CNT_W-1:0]             drop_q, drop_d;
    logic [BUF_DEPTH-1:0][31:0]   slot_pc_q, slot_pc_d;
    logic [BUF_DEPTH-1:0][31:0]   slot_data_q, slot_data_d;
    logic [BUF_DEPTH-1:0]         slot_filled_q, slot_filled_d;

    logic             req_fire;
    logic             deliver_fire;
    logic             resp_live;
    logic             resp_stale;
    logic [CNT_W-1:0] owed;

    // The low redirect bits are discarded: fetches are always word-aligned.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // ---------------- outputs ----------------
    always_comb begin
        imem_req_valid = !rst && !redirect_valid && (count_q < DEPTH_C) && (drop_q == '0);
        imem_req_addr  = fetch_pc_q;
        inst_valid     = (count_q != '0) && slot_filled_q[head_q] && !redirect_valid;
        inst           = slot_data_q[head_q];
        inst_pc        = slot_pc_q[head_q];
    end

    assign req_fire     = imem_req_valid && imem_req_ready;
    assign deliver_fire = inst_valid && inst_ready;
    // A response with nothing owed is a protocol violation and is ignored.
    assign resp_stale   = imem_resp_valid && (drop_q != '0);
    assign resp_live    = imem_resp_valid && (drop_q == '0) && (pend_q != '0);
    assign owed         = drop_q + pend_q;

    // ---------------- next state ----------------
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        alloc_d       = alloc_q;
        fill_d        = fill_q;
        head_d        = head_q;
        count_d       = count_q;
        pend_d        = pend_q;
        drop_d        = drop_q;
        slot_pc_d     = slot_pc_q;
        slot_data_d   = slot_data_q;
        slot_filled_d = slot_filled_q;

        if (redirect_valid) begin
            // Redirect overrides everything; a response landing this same
            // cycle is one of the owed ones and is discarded right here.
            fetch_pc_d    = {redirect_pc[31:2], 2'b00};
            alloc_d       = '0;
            fill_d        = '0;
            head_d        = '0;
            count_d       = '0;
            pend_d        = '0;
            slot_filled_d = '0;
            drop_d        = (imem_resp_valid && (owed != '0)) ? owed - CNT_W'(1) : owed;
        end else begin
            if (req_fire) begin
                slot_pc_d[alloc_q]     = fetch_pc_q;
                slot_filled_d[alloc_q] = 1'b0;
                alloc_d                = alloc_q + PTR_W'(1);
                fetch_pc_d             = fetch_pc_q + 32'd4;
            end
            if (resp_stale) begin
                drop_d = drop_q - CNT_W'(1);
            end else if (resp_live) begin
                slot_data_d[fill_q]   = imem_resp_data;
                slot_filled_d[fill_q] = 1'b1;
                fill_d                = fill_q + PTR_W'(1);
            end
            // fill and head never address the same slot in one cycle: head
            // must already be filled to deliver, fill is always unfilled.
            if (deliver_fire) begin
                slot_filled_d[head_q] = 1'b0;
                head_d                = head_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(req_fire) - CNT_W'(deliver_fire);
            pend_d  = pend_q + CNT_W'(req_fire) - CNT_W'(resp_live);
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            alloc_q       <= '0;
            fill_q        <= '0;
            head_q        <= '0;
            count_q       <= '0;
            pend_q        <= '0;
            drop_q        <= '0;
            slot_pc_q     <= '0;
            slot_data_q   <= '0;
            slot_filled_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            alloc_q       <= alloc_d;
            fill_q        <= fill_d;
            head_q        <= head_d;
            count_q       <= count_d;
            pend_q        <= pend_d;
            drop_q        <= drop_d;
            slot_pc_q     <= slot_pc_d;
            slot_data_q   <= slot_data_d;
            slot_filled_q <= slot_filled_d;
        end
    end

endmodule

// File: tb/tb_ysyx_24110026_ifu.sv
// ---------------------------------------------------------------------------
// tb_ysyx_24110026_ifu -- self-checking bench for ysyx_24110026_ifu.
// An in-order memory model with selectable latency answers every accepted
// request with addr ^ 32'hA5A5_0000. A per-cycle vector table covers the
// reset stream, a redirect coinciding with a response and a delivery, and
// the PC wrap; hand-written sequences cover back-pressure, a redirect with
// two requests in flight, and reset mid-stream.
// ---------------------------------------------------------------------------
module tb_ysyx_24110026_ifu;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] MAGIC    = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;

    ysyx_24110026_ifu #(.RESET_PC(RESET_PC), .BUF_DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        exp_rv;
        logic [31:0] exp_addr;
        logic        exp_iv;
        logic [31:0] exp_ipc;
    } vec_t;

    mreq_t       mq[$];
    logic [31:0] del_pc[$];
    logic [31:0] del_inst[$];
    int          cyc = 0;
    int          lat = 1;
    int          n_chk = 0;
    int          n_fail = 0;

    logic        s_rv, s_iv, s_resp;
    logic [31:0] s_addr, s_inst, s_ipc;

    function automatic logic [31:0] pa(input int k);
        return RESET_PC + 32'(4 * k);
    endfunction

    function automatic vec_t mkv(input logic rdy, input logic rd, input logic [31:0] rpc,
                                 input logic rv, input logic [31:0] ra,
                                 input logic iv, input logic [31:0] ipc);
        vec_t v;
        v.rdy = rdy; v.redir = rd; v.rpc = rpc;
        v.exp_rv = rv; v.exp_addr = ra; v.exp_iv = iv; v.exp_ipc = ipc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: memory drives its response, outputs are sampled
    // mid-cycle, then the edge is taken and the model is updated.
    task automatic tick();
        mreq_t m;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mq[0].addr ^ MAGIC;
        end
        #2;
        s_rv   = imem_req_valid;
        s_addr = imem_req_addr;
        s_iv   = inst_valid;
        s_inst = inst;
        s_ipc  = inst_pc;
        s_resp = imem_resp_valid;
        if (s_resp) assert (mq.size() > 0) else $error("response with nothing outstanding");
        @(posedge clk);
        if (rst) begin
            mq.delete();
        end else begin
            if (s_resp) void'(mq.pop_front());
            if (s_rv && imem_req_ready) begin
                m.addr = s_addr;
                m.due  = cyc + lat;
                mq.push_back(m);
            end
            if (s_iv && inst_ready) begin
                del_pc.push_back(s_ipc);
                del_inst.push_back(s_inst);
            end
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        inst_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        del_pc.delete();
        del_inst.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt[15];
        int nf;

        // ---- reset values (sampled after a reset edge, rst still high) ----
        do_reset();
        check("rst req_valid", s_rv, 0);
        check("rst inst_valid", s_iv, 0);
        check("rst req_addr", s_addr, RESET_PC);
        check("rst inst", s_inst, 0);
        check("rst inst_pc", s_ipc, 0);

        // ---- table: stream, redirect+response+handshake, PC wrap ----
        vt[0]  = mkv(1, 0, 0,              1, pa(0),           0, 0);
        vt[1]  = mkv(1, 0, 0,              1, pa(1),           0, 0);
        vt[2]  = mkv(1, 0, 0,              0, pa(2),           1, pa(0));
        vt[3]  = mkv(1, 0, 0,              1, pa(2),           1, pa(1));
        vt[4]  = mkv(1, 0, 0,              1, pa(3),           0, 0);
        vt[5]  = mkv(1, 1, 32'h8000_0203,  0, pa(4),           0, 0);
        vt[6]  = mkv(1, 0, 0,              1, 32'h8000_0200,   0, 0);
        vt[7]  = mkv(1, 0, 0,              1, 32'h8000_0204,   0, 0);
        vt[8]  = mkv(1, 0, 0,              0, 32'h8000_0208,   1, 32'h8000_0200);
        vt[9]  = mkv(1, 0, 0,              1, 32'h8000_0208,   1, 32'h8000_0204);
        vt[10] = mkv(1, 1, 32'hFFFF_FFFC,  0, 32'h8000_020C,   0, 0);
        vt[11] = mkv(1, 0, 0,              1, 32'hFFFF_FFFC,   0, 0);
        vt[12] = mkv(1, 0, 0,              1, 32'h0000_0000,   0, 0);
        vt[13] = mkv(1, 0, 0,              0, 32'h0000_0004,   1, 32'hFFFF_FFFC);
        vt[14] = mkv(1, 0, 0,              1, 32'h0000_0004,   1, 32'h0000_0000);

        lat = 1;
        for (int i = 0; i < 15; i++) begin
            inst_ready     = vt[i].rdy;
            redirect_valid = vt[i].redir;
            redirect_pc    = vt[i].rpc;
            tick();
            check($sformatf("v%0d req_valid", i), s_rv, vt[i].exp_rv);
            check($sformatf("v%0d req_addr", i), s_addr, vt[i].exp_addr);
            check($sformatf("v%0d inst_valid", i), s_iv, vt[i].exp_iv);
            if (vt[i].exp_iv) begin
                check($sformatf("v%0d inst_pc", i), s_ipc, vt[i].exp_ipc);
                check($sformatf("v%0d inst", i), s_inst, vt[i].exp_ipc ^ MAGIC);
            end
        end
        redirect_valid = 1'b0;
        // Only live instructions may ever have been handed over.
        check("table delivered count", 32'(del_pc.size()), 6);

        // ---- back-pressure: inst_ready low for 5 cycles ----
        do_reset();
        lat = 1;
        inst_ready = 1'b0;
        nf = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (s_rv && imem_req_ready) nf++;
            if (i >= 2) begin
                check($sformatf("bp%0d inst_valid", i), s_iv, 1);
                check($sformatf("bp%0d inst_pc held", i), s_ipc, pa(0));
                check($sformatf("bp%0d inst held", i), s_inst, pa(0) ^ MAGIC);
            end
        end
        check("bp accepted", 32'(nf), 2);
        check("bp req_valid low", s_rv, 0);
        inst_ready = 1'b1;
        for (int i = 0; i < 20 && del_pc.size() < 4; i++) tick();
        check("bp resume count", 32'(del_pc.size() >= 4), 1);
        for (int k = 0; k < 4; k++) begin
            if (del_pc.size() > k) begin
                check($sformatf("bp order pc%0d", k), del_pc[k], pa(k));
                check($sformatf("bp order inst%0d", k), del_inst[k], pa(k) ^ MAGIC);
            end
        end

        // ---- redirect with two requests in flight, 3-cycle memory ----
        do_reset();
        lat = 3;
        inst_ready = 1'b1;
        tick();
        check("rd c0 req", s_rv, 1);
        tick();
        check("rd c1 addr", s_addr, pa(1));
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0102;
        tick();
        check("rd R req_valid", s_rv, 0);
        check("rd R inst_valid", s_iv, 0);
        redirect_valid = 1'b0;
        tick();
        check("rd R+1 addr", s_addr, 32'h8000_0100);
        check("rd R+1 req_valid", s_rv, 0);
        tick();
        check("rd R+2 req_valid", s_rv, 0);
        tick();
        check("rd R+3 req_valid", s_rv, 1);
        check("rd R+3 addr", s_addr, 32'h8000_0100);
        for (int i = 0; i < 12 && del_pc.size() == 0; i++) tick();
        check("rd delivered", 32'(del_pc.size() > 0), 1);
        if (del_pc.size() > 0) begin
            check("rd first pc", del_pc[0], 32'h8000_0100);
            check("rd first inst", del_inst[0], 32'h8000_0100 ^ MAGIC);
        end

        // ---- reset mid-stream: buffer full, two requests outstanding ----
        do_reset();
        lat = 3;
        inst_ready = 1'b0;
        tick();
        tick();
        tick();
        check("mr full req_valid", s_rv, 0);
        rst = 1'b1;
        tick();
        check("mr rst req_valid", s_rv, 0);
        rst = 1'b0;
        lat = 1;
        del_pc.delete();
        del_inst.delete();
        tick();
        check("mr req_valid", s_rv, 1);
        check("mr req_addr", s_addr, RESET_PC);
        check("mr inst_valid", s_iv, 0);
        check("mr inst", s_inst, 0);
        check("mr inst_pc", s_ipc, 0);
        inst_ready = 1'b1;
        for (int i = 0; i < 20 && del_pc.size() < 2; i++) tick();
        check("mr delivered", 32'(del_pc.size() >= 2), 1);
        if (del_pc.size() >= 2) begin
            check("mr pc0", del_pc[0], pa(0));
            check("mr pc1", del_pc[1], pa(1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
